// File: rtl/restador_serial_ctrl_if.sv
// restador_serial_ctrl_if: start/done handshake bus; carries ovf only when RESTADOR_OVF_EN is defined
interface restador_serial_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             bout;
`ifdef RESTADOR_OVF_EN
    logic             ovf;
`endif
    modport master (
        output start, a, b, bin,
`ifdef RESTADOR_OVF_EN
        input  ovf,
`endif
        input  busy, done, result, bout
    );
    modport slave (
        input  start, a, b, bin,
`ifdef RESTADOR_OVF_EN
        output ovf,
`endif
        output busy, done, result, bout
    );
endinterface

// File: rtl/restador_serial_ctrl.sv
// restador_serial_ctrl: bit-serial a-b-bin, LSB first, one restador1bit cell; RESTADOR_OVF_EN adds signed overflow
module restador1bit (
    output logic restaOut,
    output logic c_out,
    input  logic A,
    input  logic B,
    input  logic c_in
);
    assign restaOut = A ^ B ^ c_in;
    assign c_out    = (~A & B) | (~(A ^ B) & c_in);
endmodule

module restador_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    restador_serial_ctrl_if.slave        bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, result_q, r_nx;
    logic [WIDTH-2:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             brw, d, c_out, last, accept, bout_q;
    restador1bit u_cell (
        .restaOut (d),
        .c_out    (c_out),
        .A        (a_sr[0]),
        .B        (b_sr[0]),
        .c_in     (brw)
    );
    assign last   = cnt == CW'(WIDTH - 1);
    assign accept = bus.start && state != RUN;
    // r_sr keeps the bits gathered so far; r_nx is the full word including the current bit
    assign r_nx   = {d, r_sr};
    always_comb begin
        state_d = state;
        state_d = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            bout_q   <= 1'b0;
        end else if (accept) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            brw  <= bus.bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_nx[WIDTH-1:1];
            brw  <= c_out;
            cnt  <= last ? '0 : cnt + 1'b1;
            if (last) begin
                result_q <= r_nx;
                bout_q   <= c_out;
            end
        end
    end
`ifdef RESTADOR_OVF_EN
    logic am, bm, ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am    <= 1'b0;
            bm    <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            am <= bus.a[WIDTH-1];
            bm <= bus.b[WIDTH-1];
        end else if (state == RUN && last) begin
            ovf_q <= (am != bm) && (d != am);
        end
    end
    assign bus.ovf = ovf_q;
`endif
    assign bus.busy   = state == RUN;
    assign bus.done   = state == DONE;
    assign bus.result = result_q;
    assign bus.bout   = bout_q;
endmodule

// File: tb/tb_restador_serial_ctrl.sv
// tb_restador_serial_ctrl: directed checks of the serial subtractor controller at WIDTH=8
module tb_restador_serial_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass = 0;
    int   total = 0;
    restador_serial_ctrl_if #(.WIDTH(8)) bus ();
    restador_serial_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // issues one operation and measures busy cycles and the cycle (accept cycle = 1) on which done rises
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         output int busy_n, output int lat, output int both);
        bus.start = 1'b1;
        bus.a = ia;
        bus.b = ib;
        bus.bin = ibin;
        step();
        bus.start = 1'b0;
        busy_n = 0;
        lat = -1;
        both = 0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) both++;
            if (bus.done) lat = i + 1;
            else step();
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset busy got %b want 0", bus.busy); else pass++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset done got %b want 0", bus.done); else pass++;
        total++; if (bus.result !== 8'h00) $display("FAIL reset result got %h want 00", bus.result); else pass++;
        total++; if (bus.bout !== 1'b0) $display("FAIL reset bout got %b want 0", bus.bout); else pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        int bn, lat, both;
        do_op(8'h05, 8'h03, 1'b0, bn, lat, both);
        total++; if (bn !== 8) $display("FAIL op1 busy cycles got %0d want 8", bn); else pass++;
        total++; if (lat !== 9) $display("FAIL op1 done cycle got %0d want 9", lat); else pass++;
        total++; if (both !== 0) $display("FAIL op1 busy&done overlap got %0d want 0", both); else pass++;
        total++; if (bus.result !== 8'h02) $display("FAIL op1 result got %h want 02", bus.result); else pass++;
        total++; if (bus.bout !== 1'b0) $display("FAIL op1 bout got %b want 0", bus.bout); else pass++;
        step();
        total++; if (bus.done !== 1'b0) $display("FAIL op1 done width got %b want 0", bus.done); else pass++;
    endtask

    task automatic test_borrow;
        int bn, lat, both;
        do_op(8'h03, 8'h05, 1'b0, bn, lat, both);
        total++; if (bus.result !== 8'hFE) $display("FAIL neg result got %h want fe", bus.result); else pass++;
        total++; if (bus.bout !== 1'b1) $display("FAIL neg bout got %b want 1", bus.bout); else pass++;
        do_op(8'h00, 8'h00, 1'b1, bn, lat, both);
        total++; if (bus.result !== 8'hFF) $display("FAIL bin result got %h want ff", bus.result); else pass++;
        total++; if (bus.bout !== 1'b1) $display("FAIL bin bout got %b want 1", bus.bout); else pass++;
        do_op(8'hFF, 8'hFF, 1'b0, bn, lat, both);
        total++; if (bus.result !== 8'h00) $display("FAIL eq result got %h want 00", bus.result); else pass++;
        total++; if (bus.bout !== 1'b0) $display("FAIL eq bout got %b want 0", bus.bout); else pass++;
        step();
    endtask

    task automatic test_back_to_back;
        int n;
        bus.start = 1'b1;
        bus.a = 8'hA0;
        bus.b = 8'h0F;
        bus.bin = 1'b0;
        step();
        bus.a = 8'h10;
        bus.b = 8'h10;
        for (int i = 0; i < 40 && !bus.done; i++) step();
        total++; if (bus.result !== 8'h91) $display("FAIL b2b first result got %h want 91", bus.result); else pass++;
        step();
        total++; if (bus.busy !== 1'b1) $display("FAIL b2b no idle busy got %b want 1", bus.busy); else pass++;
        bus.start = 1'b0;
        total++; if (bus.result !== 8'h91) $display("FAIL b2b result held got %h want 91", bus.result); else pass++;
        for (n = 1; n < 40 && !bus.done; n++) step();
        total++; if (n !== 9) $display("FAIL b2b done spacing got %0d want 9", n); else pass++;
        total++; if (bus.result !== 8'h00) $display("FAIL b2b second result got %h want 00", bus.result); else pass++;
        total++; if (bus.bout !== 1'b0) $display("FAIL b2b second bout got %b want 0", bus.bout); else pass++;
        step();
    endtask

    task automatic test_start_ignored;
        int n = 0;
        bus.start = 1'b1;
        bus.a = 8'h05;
        bus.b = 8'h03;
        bus.bin = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        bus.a = 8'h33;
        bus.b = 8'h11;
        bus.bin = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) n++;
            step();
        end
        total++; if (n !== 1) $display("FAIL ignore done pulses got %0d want 1", n); else pass++;
        total++; if (bus.result !== 8'h02) $display("FAIL ignore result got %h want 02", bus.result); else pass++;
        total++; if (bus.bout !== 1'b0) $display("FAIL ignore bout got %b want 0", bus.bout); else pass++;
    endtask

    task automatic test_reset_mid_run;
        int bn, lat, both, n = 0;
        do_op(8'h03, 8'h05, 1'b0, bn, lat, both);
        step();
        bus.start = 1'b1;
        bus.a = 8'hA0;
        bus.b = 8'h0F;
        bus.bin = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort busy got %b want 0", bus.busy); else pass++;
        total++; if (bus.done !== 1'b0) $display("FAIL abort done got %b want 0", bus.done); else pass++;
        total++; if (bus.result !== 8'h00) $display("FAIL abort result got %h want 00", bus.result); else pass++;
        total++; if (bus.bout !== 1'b0) $display("FAIL abort bout got %b want 0", bus.bout); else pass++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (bus.done || bus.busy) n++;
            step();
        end
        total++; if (n !== 0) $display("FAIL abort activity after release got %0d want 0", n); else pass++;
        do_op(8'h05, 8'h03, 1'b0, bn, lat, both);
        total++; if (lat !== 9) $display("FAIL abort restart done cycle got %0d want 9", lat); else pass++;
        total++; if (bus.result !== 8'h02) $display("FAIL abort restart result got %h want 02", bus.result); else pass++;
        step();
    endtask

`ifdef RESTADOR_OVF_EN
    task automatic test_ovf;
        int bn, lat, both;
        do_op(8'h80, 8'h01, 1'b0, bn, lat, both);
        total++; if (bus.result !== 8'h7F) $display("FAIL ovf1 result got %h want 7f", bus.result); else pass++;
        total++; if (bus.ovf !== 1'b1) $display("FAIL ovf1 ovf got %b want 1", bus.ovf); else pass++;
        do_op(8'h7F, 8'hFF, 1'b0, bn, lat, both);
        total++; if (bus.result !== 8'h80) $display("FAIL ovf2 result got %h want 80", bus.result); else pass++;
        total++; if (bus.ovf !== 1'b1) $display("FAIL ovf2 ovf got %b want 1", bus.ovf); else pass++;
        do_op(8'h05, 8'h03, 1'b0, bn, lat, both);
        total++; if (bus.ovf !== 1'b0) $display("FAIL ovf3 ovf got %b want 0", bus.ovf); else pass++;
        step();
    endtask
`else
    task automatic test_ovf;
        $display("ovf port absent in this build");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_ovf();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
